dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the shared Y86 data memory.
- Requester 0 is the CPU memory stage; requester 1 is the program loader / debug port.
- Arbitrates round-robin and runs a fixed 3-cycle IDLE→ACCESS→RESP sequence that drives the data memory's mem_read/mem_write/mem_addr/mem_data.
- Returns read data and error status to the winning requester with a valid pulse.

Parameters:
- ADDR_W, 64, address width of requesters and memory.
- DATA_W, 64, data width (8-byte little-endian word).
- MEM_BYTES, 256, memory size in bytes; bound for the arbiter's own address check.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  request, requester 0 (CPU).
- we0  input  1  1 = write, 0 = read; requester 0.
- addr0  input  ADDR_W  byte address, requester 0.
- wdata0  input  DATA_W  write data, requester 0.
- gnt0  output  1  one-cycle grant pulse, requester 0.
- rvalid0  output  1  one-cycle response pulse, requester 0.
- rdata0  output  DATA_W  read data, valid with rvalid0.
- err0  output  1  access error, valid with rvalid0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same roles for requester 1.
- mem_read  output  1  drives the data memory's read enable.
- mem_write  output  1  drives the data memory's write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_data  output  DATA_W  memory write data.
- valM  input  DATA_W  memory read data (combinational from mem_addr).
- dmem_error  input  1  memory's address error flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - All outputs 0; state = IDLE; last_gnt = 1, so requester 0 wins the first tie.
  - Latched id/we/addr/wdata/rdata/err registers are cleared.
- FSM states: IDLE, ACCESS, RESP. Every transition is registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester ≠ last_gnt wins (round-robin).
  - On the winning edge: latch id, we, addr, wdata; set last_gnt = id; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt<id> = 1.
  - mem_addr = latched addr; mem_data = latched wdata.
  - oob = (addr > MEM_BYTES-8), computed on the full ADDR_W width with no wrap.
  - If !oob: mem_write = we, mem_read = !we. If oob: both are 0 and memory is untouched.
  - End-of-cycle edge:
    - A write commits in memory.
    - rdata_q = (!we && !oob) ? valM : 0.
    - err_q = oob | dmem_error.
  - Next state RESP.
- RESP (exactly 1 cycle):
  - rvalid<id> = 1; rdata<id> = rdata_q; err<id> = err_q.
  - Non-winner outputs stay 0. mem_read/mem_write = 0.
  - Next state IDLE.
- Latency and throughput:
  - Request seen in IDLE at edge N → gnt high in cycle N+1 → rvalid high in cycle N+2.
  - One access per 3 cycles maximum.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until gnt is seen, and drops req no later than the RESP cycle.
  - req is ignored in ACCESS and RESP; a req still high in IDLE is a new request.
  - Requester inputs are sampled only in IDLE, so input changes during ACCESS/RESP have no effect.
- Signal shape and port isolation:
  - gnt, rvalid, mem_read and mem_write are never high for more than one consecutive cycle.
  - The two ports are never granted in the same cycle.
- Starvation: a requester holding req waits at most one other access (3 cycles) before it is granted.
- Reset mid-operation: immediate return to IDLE with all outputs 0.
  - A write whose ACCESS cycle was aborted by reset does not commit.
  - last_gnt returns to 1.
- rdata/err hold their value outside RESP only internally; the ports are 0 when rvalid is 0.

Test Plan:
- Single read: after reset, memory bytes 0x10..0x17 preloaded to 0x1122334455667788; req0 with we0=0, addr0=0x10 for one edge → gnt0 next cycle; rvalid0 the cycle after with rdata0=0x1122334455667788, err0=0.
- Write then read: req1 writes 0xDEADBEEFCAFEF00D to addr 0x20, then req1 reads 0x20 → exactly one mem_write pulse with mem_addr=0x20; read returns rdata1=0xDEADBEEFCAFEF00D.
- Round-robin: req0 and req1 held high continuously from reset → grant order gnt0, gnt1, gnt0, gnt1, with gnts spaced 3 cycles apart and never simultaneous.
- Out-of-bounds write: req0 we0=1, addr0=0xF9 (MEM_BYTES=256) → mem_write stays 0; rvalid0 with err0=1, rdata0=0; bytes 0xF9..0xFF unchanged on readback.
- Reset mid-access: assert rst_n=0 during the ACCESS cycle of a write to 0x30 → all outputs 0 immediately; readback of 0x30 returns 0. Next tie after reset is granted to requester 0.
- Input change after grant: change addr0 during the RESP cycle → the response reflects the originally latched address; no extra gnt occurs if req0 is low by IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the data memory.
// The slave modport is the arbiter's view; master is the view of whatever surrounds it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Requester 0 (CPU memory stage)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  // Requester 1 (program loader / debug port)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  // Data memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] valM;
  logic              dmem_error;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0, err0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1, err1,
    output mem_read, mem_write, mem_addr, mem_data,
    input  valM, dmem_error
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0, err0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1, err1,
    input  mem_read, mem_write, mem_addr, mem_data,
    output valM, dmem_error
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and fixed IDLE->ACCESS->RESP sequencer for the shared
// Y86 data memory; one access per three cycles, response returned with a one-cycle pulse.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until its gnt
  // pulse (the ACCESS cycle); req is only sampled in IDLE, so it must be dropped by the
  // RESP cycle unless another access is wanted. rvalid/rdata/err form a one-cycle
  // response in RESP; rdata/err read as 0 whenever rvalid is low.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              win_valid;
  logic              win_id;
  logic              oob;

  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // Full-width compare: an address near the top of the ADDR_W range must not wrap in.
  assign oob = (addr_q > LAST_ADDR);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win_id = ~last_gnt_q;
    end else begin
      win_id = bus.req1;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    rdata0     = '0;
    rdata1     = '0;
    err0       = 1'b0;
    err1       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          id_d       = win_id;
          last_gnt_d = win_id;
          we_d       = win_id ? bus.we1    : bus.we0;
          addr_d     = win_id ? bus.addr1  : bus.addr0;
          wdata_d    = win_id ? bus.wdata1 : bus.wdata0;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        gnt0      = ~id_q;
        gnt1      = id_q;
        mem_addr  = addr_q;
        mem_data  = wdata_q;
        mem_write = we_q & ~oob;
        mem_read  = ~we_q & ~oob;
        rdata_d   = (!we_q && !oob) ? bus.valM : '0;
        err_d     = oob | bus.dmem_error;
        state_d   = RESP;
      end

      RESP: begin
        rvalid0 = ~id_q;
        rvalid1 = id_q;
        rdata0  = id_q ? '0 : rdata_q;
        rdata1  = id_q ? rdata_q : '0;
        err0    = ~id_q & err_q;
        err1    = id_q & err_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
  assign bus.err0      = err0;
  assign bus.err1      = err1;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_data  = mem_data;
  assign dbg_state     = state_q;

endmodule
